// File: rtl/inst_axi_fetch.sv
// Instruction-fetch bridge: two IF request slots, round-robin arbitration and
// single-beat AXI reads with one transaction outstanding at a time.
module inst_axi_fetch #(
   parameter logic [3:0] AXI_ID = 4'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_1,
   input  logic [31:0] pc_1,
   input  logic        req_2,
   input  logic [31:0] pc_2,
   input  logic        flush,
   output logic        busy_1,
   output logic        busy_2,
   output logic        inst_valid_1,
   output logic [31:0] inst_1,
   output logic        inst_err_1,
   output logic        inst_valid_2,
   output logic [31:0] inst_2,
   output logic        inst_err_2,
   output logic        arvalid,
   output logic [31:0] araddr,
   output logic [3:0]  arid,
   output logic [3:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   input  logic        arready,
   input  logic        rvalid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   output logic        rready
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t      state;
   logic [1:0]  slot_v, req, cap, pend, fault, inst_valid, inst_err;
   logic [31:0] pc [2];
   logic [31:0] slot_addr [2];
   logic [31:0] cur_addr [2];
   logic [31:0] inst [2];
   logic        last_grant, gnt, gsel, discard, resp_err;

   assign req      = {req_2, req_1};
   assign pc[0]    = pc_1;
   assign pc[1]    = pc_2;
   assign resp_err = rresp inside {2'b10, 2'b11};

   assign arid    = AXI_ID;
   assign arlen   = 4'd0;
   assign arsize  = 3'b010;
   assign arburst = 2'b01;
   assign arlock  = 2'b00;
   assign arcache = 4'd0;
   assign arprot  = 3'd0;

   assign busy_1       = slot_v[0];
   assign busy_2       = slot_v[1];
   assign inst_valid_1 = inst_valid[0];
   assign inst_valid_2 = inst_valid[1];
   assign inst_err_1   = inst_err[0];
   assign inst_err_2   = inst_err[1];
   assign inst_1       = inst[0];
   assign inst_2       = inst[1];

   // A request arriving on this edge is already visible to the arbiter, so the
   // grant can happen on the capture edge itself.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      cap      = '0;
      pend     = '0;
      fault    = '0;
      cur_addr = '{default: '0};
      for (int n = 0; n < 2; n++) begin
         cap[n]      = req[n] & ~slot_v[n] & ~flush;
         cur_addr[n] = slot_v[n] ? slot_addr[n] : pc[n];
         pend[n]     = ~flush & (slot_v[n] | cap[n]) & (cur_addr[n][1:0] == 2'b00);
         fault[n]    = ~flush & slot_v[n] & (slot_addr[n][1:0] != 2'b00);
      end
      gsel = (pend == 2'b11) ? ~last_grant : pend[1];
   end

   // NOTE: all state uses non-blocking assignments; later statements in the block win.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         slot_v     <= '0;
         slot_addr  <= '{default: '0};
         inst       <= '{default: '0};
         inst_valid <= '0;
         inst_err   <= '0;
         last_grant <= 1'b1;
         gnt        <= 1'b0;
         discard    <= 1'b0;
         arvalid    <= 1'b0;
         araddr     <= '0;
         rready     <= 1'b0;
      end else begin
         inst_valid <= '0;
         inst_err   <= '0;
         for (int n = 0; n < 2; n++) begin
            if (flush) begin
               slot_v[n] <= 1'b0;
            end else if (cap[n]) begin
               slot_v[n]    <= 1'b1;
               slot_addr[n] <= pc[n];
            end else if (fault[n]) begin
               slot_v[n]   <= 1'b0;
               inst_err[n] <= 1'b1;
               inst[n]     <= '0;
            end
         end
         case (state)
            IDLE: begin
               discard <= 1'b0;
               if (pend != 2'b00) begin
                  araddr     <= {cur_addr[gsel][31:2], 2'b00};
                  arvalid    <= 1'b1;
                  gnt        <= gsel;
                  last_grant <= gsel;
                  state      <= ADDR;
               end
            end
            ADDR: begin
               if (flush) discard <= 1'b1;
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= DATA;
               end
            end
            DATA: begin
               if (flush) discard <= 1'b1;
               if (rvalid) begin
                  rready  <= 1'b0;
                  state   <= IDLE;
                  discard <= 1'b0;
                  // A flushed beat is swallowed; the slot may already hold a new request.
                  if (!discard && !flush) begin
                     slot_v[gnt] <= 1'b0;
                     if (resp_err) begin
                        inst_err[gnt] <= 1'b1;
                     end else begin
                        inst[gnt]       <= rdata;
                        inst_valid[gnt] <= 1'b1;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_axi_fetch.sv
// Directed bench for inst_axi_fetch: one task per scenario with inline comparisons
// against hand-computed values.
module tb_inst_axi_fetch;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_1 = 1'b0, req_2 = 1'b0, flush = 1'b0;
   logic [31:0] pc_1 = '0, pc_2 = '0;
   logic        busy_1, busy_2, inst_valid_1, inst_err_1, inst_valid_2, inst_err_2;
   logic [31:0] inst_1, inst_2, araddr;
   logic        arvalid, rready;
   logic [3:0]  arid, arlen, arcache;
   logic [2:0]  arsize, arprot;
   logic [1:0]  arburst, arlock;
   logic        arready = 1'b0, rvalid = 1'b0;
   logic [31:0] rdata = '0;
   logic [1:0]  rresp = '0;

   int checks = 0;
   int errors = 0;

   inst_axi_fetch #(.AXI_ID(4'd0)) dut (
      .clk(clk), .reset(reset),
      .req_1(req_1), .pc_1(pc_1), .req_2(req_2), .pc_2(pc_2), .flush(flush),
      .busy_1(busy_1), .busy_2(busy_2),
      .inst_valid_1(inst_valid_1), .inst_1(inst_1), .inst_err_1(inst_err_1),
      .inst_valid_2(inst_valid_2), .inst_2(inst_2), .inst_err_2(inst_err_2),
      .arvalid(arvalid), .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
      .arready(arready), .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout got no finish exp finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req_1 = 1'b0; req_2 = 1'b0; flush = 1'b0;
      arready = 1'b0; rvalid = 1'b0; rresp = 2'b00;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid got %h exp 0", arvalid); end
      checks++; if (araddr !== 32'h0) begin errors++; $display("FAIL reset_araddr got %h exp 0", araddr); end
      checks++; if (rready !== 1'b0) begin errors++; $display("FAIL reset_rready got %h exp 0", rready); end
      checks++; if ({busy_1, busy_2} !== 2'b00) begin errors++; $display("FAIL reset_busy got %b exp 00", {busy_1, busy_2}); end
      checks++; if ({inst_valid_1, inst_valid_2, inst_err_1, inst_err_2} !== 4'b0000) begin errors++; $display("FAIL reset_pulses got %b exp 0000", {inst_valid_1, inst_valid_2, inst_err_1, inst_err_2}); end
      checks++; if ({inst_1, inst_2} !== 64'h0) begin errors++; $display("FAIL reset_inst got %h exp 0", {inst_1, inst_2}); end
      checks++; if ({arid, arlen, arsize, arburst, arlock, arcache, arprot} !== {4'd0, 4'd0, 3'b010, 2'b01, 2'b00, 4'd0, 3'd0}) begin errors++; $display("FAIL reset_ar_const got %h", {arid, arlen, arsize, arburst, arlock, arcache, arprot}); end
   endtask

   task automatic test_single();
      arready = 1'b1;
      req_1 = 1'b1; pc_1 = 32'hBFC0_0000;
      tick();
      req_1 = 1'b0;
      checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL single_arvalid got %h exp 1", arvalid); end
      checks++; if (araddr !== 32'hBFC0_0000) begin errors++; $display("FAIL single_araddr got %h exp bfc00000", araddr); end
      checks++; if (busy_1 !== 1'b1) begin errors++; $display("FAIL single_busy got %h exp 1", busy_1); end
      tick();
      checks++; if ({arvalid, rready} !== 2'b01) begin errors++; $display("FAIL single_data_phase got %b exp 01", {arvalid, rready}); end
      rvalid = 1'b1; rdata = 32'h3C08_0001;
      tick();
      rvalid = 1'b0;
      checks++; if (inst_valid_1 !== 1'b1) begin errors++; $display("FAIL single_valid got %h exp 1", inst_valid_1); end
      checks++; if (inst_1 !== 32'h3C08_0001) begin errors++; $display("FAIL single_inst got %h exp 3c080001", inst_1); end
      checks++; if ({busy_1, inst_valid_2, rready} !== 3'b000) begin errors++; $display("FAIL single_after got %b exp 000", {busy_1, inst_valid_2, rready}); end
      tick();
      checks++; if (inst_valid_1 !== 1'b0 || inst_1 !== 32'h3C08_0001) begin errors++; $display("FAIL single_hold got %h/%h exp 0/3c080001", inst_valid_1, inst_1); end
   endtask

   task automatic test_contention();
      do_reset();
      arready = 1'b1;
      req_1 = 1'b1; pc_1 = 32'h100;
      req_2 = 1'b1; pc_2 = 32'h104;
      tick();
      req_1 = 1'b0; req_2 = 1'b0;
      checks++; if (araddr !== 32'h100 || arvalid !== 1'b1) begin errors++; $display("FAIL cont_first_grant got %h exp 00000100", araddr); end
      checks++; if ({busy_1, busy_2} !== 2'b11) begin errors++; $display("FAIL cont_busy got %b exp 11", {busy_1, busy_2}); end
      tick();
      rvalid = 1'b1; rdata = 32'h1111_1111;
      tick();
      rvalid = 1'b0;
      checks++; if (inst_valid_1 !== 1'b1 || inst_1 !== 32'h1111_1111) begin errors++; $display("FAIL cont_deliver1 got %h/%h exp 1/11111111", inst_valid_1, inst_1); end
      // Port 1 re-requests as port 2 still waits: the tie must now go to port 2.
      req_1 = 1'b1; pc_1 = 32'h108;
      tick();
      req_1 = 1'b0;
      checks++; if (araddr !== 32'h104 || arvalid !== 1'b1) begin errors++; $display("FAIL cont_rr_grant got %h exp 00000104", araddr); end
      checks++; if (busy_1 !== 1'b1) begin errors++; $display("FAIL cont_recapture got %h exp 1", busy_1); end
      tick();
      rvalid = 1'b1; rdata = 32'h2222_2222;
      tick();
      rvalid = 1'b0;
      checks++; if (inst_valid_2 !== 1'b1 || inst_2 !== 32'h2222_2222 || inst_valid_1 !== 1'b0) begin errors++; $display("FAIL cont_deliver2 got %h/%h exp 1/22222222", inst_valid_2, inst_2); end
      tick();
      checks++; if (araddr !== 32'h108 || arvalid !== 1'b1) begin errors++; $display("FAIL cont_third_grant got %h exp 00000108", araddr); end
      tick();
      rvalid = 1'b1; rdata = 32'h3333_3333;
      tick();
      rvalid = 1'b0;
      checks++; if (inst_valid_1 !== 1'b1 || inst_1 !== 32'h3333_3333 || inst_valid_2 !== 1'b0) begin errors++; $display("FAIL cont_deliver3 got %h/%h exp 1/33333333", inst_valid_1, inst_1); end
   endtask

   task automatic test_backpressure();
      arready = 1'b0;
      req_1 = 1'b1; pc_1 = 32'h2000;
      tick();
      req_1 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++; if (arvalid !== 1'b1 || araddr !== 32'h2000 || busy_1 !== 1'b1) begin errors++; $display("FAIL bp_hold%0d got %h/%h/%h exp 1/00002000/1", i, arvalid, araddr, busy_1); end
         tick();
      end
      checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL bp_still_valid got %h exp 1", arvalid); end
      arready = 1'b1;
      tick();
      checks++; if (arvalid !== 1'b0 || rready !== 1'b1) begin errors++; $display("FAIL bp_handshake got %h/%h exp 0/1", arvalid, rready); end
      rvalid = 1'b1; rdata = 32'h4444_4444;
      tick();
      rvalid = 1'b0;
      checks++; if (inst_valid_1 !== 1'b1 || inst_1 !== 32'h4444_4444 || busy_1 !== 1'b0) begin errors++; $display("FAIL bp_deliver got %h/%h exp 1/44444444", inst_valid_1, inst_1); end
   endtask

   task automatic test_flush_data();
      req_1 = 1'b1; pc_1 = 32'h3000;
      tick();
      req_1 = 1'b0;
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (busy_1 !== 1'b0 || rready !== 1'b1) begin errors++; $display("FAIL flush_clear got %h/%h exp 0/1", busy_1, rready); end
      rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
      tick();
      rvalid = 1'b0;
      checks++; if (inst_valid_1 !== 1'b0 || inst_err_1 !== 1'b0) begin errors++; $display("FAIL flush_no_pulse got %h/%h exp 0/0", inst_valid_1, inst_err_1); end
      checks++; if (inst_1 !== 32'h4444_4444) begin errors++; $display("FAIL flush_inst_kept got %h exp 44444444", inst_1); end
      checks++; if (rready !== 1'b0) begin errors++; $display("FAIL flush_rready got %h exp 0", rready); end
      req_1 = 1'b1; pc_1 = 32'h3004;
      tick();
      req_1 = 1'b0;
      checks++; if (arvalid !== 1'b1 || araddr !== 32'h3004) begin errors++; $display("FAIL flush_idle_grant got %h/%h exp 1/00003004", arvalid, araddr); end
      tick();
      rvalid = 1'b1; rdata = 32'h5555_5555;
      tick();
      rvalid = 1'b0;
      checks++; if (inst_valid_1 !== 1'b1 || inst_1 !== 32'h5555_5555) begin errors++; $display("FAIL flush_next_deliver got %h/%h exp 1/55555555", inst_valid_1, inst_1); end
   endtask

   task automatic test_misaligned();
      int seen = 0;
      req_2 = 1'b1; pc_2 = 32'h102;
      tick();
      req_2 = 1'b0;
      checks++; if (arvalid !== 1'b0 || busy_2 !== 1'b1) begin errors++; $display("FAIL mis_capture got %h/%h exp 0/1", arvalid, busy_2); end
      for (int i = 0; i < 4 && seen == 0; i++) begin
         tick();
         checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL mis_no_ar got %h exp 0", arvalid); end
         if (inst_err_2 === 1'b1) seen = 1;
      end
      checks++; if (seen != 1) begin errors++; $display("FAIL mis_err_pulse got none exp pulse"); end
      checks++; if (inst_2 !== 32'h0 || inst_valid_2 !== 1'b0 || busy_2 !== 1'b0) begin errors++; $display("FAIL mis_state got %h/%h/%h exp 0/0/0", inst_2, inst_valid_2, busy_2); end
      tick();
      checks++; if (inst_err_2 !== 1'b0) begin errors++; $display("FAIL mis_err_width got %h exp 0", inst_err_2); end
   endtask

   task automatic test_rresp_err();
      req_1 = 1'b1; pc_1 = 32'h4000;
      tick();
      req_1 = 1'b0;
      checks++; if (araddr !== 32'h4000) begin errors++; $display("FAIL rerr_araddr got %h exp 00004000", araddr); end
      tick();
      rvalid = 1'b1; rdata = 32'h9999_9999; rresp = 2'b10;
      tick();
      rvalid = 1'b0; rresp = 2'b00;
      checks++; if (inst_err_1 !== 1'b1 || inst_valid_1 !== 1'b0) begin errors++; $display("FAIL rerr_pulse got %h/%h exp 1/0", inst_err_1, inst_valid_1); end
      checks++; if (inst_1 !== 32'h5555_5555 || busy_1 !== 1'b0) begin errors++; $display("FAIL rerr_inst got %h/%h exp 55555555/0", inst_1, busy_1); end
      tick();
      checks++; if (inst_err_1 !== 1'b0) begin errors++; $display("FAIL rerr_width got %h exp 0", inst_err_1); end
   endtask

   task automatic test_async_reset();
      arready = 1'b0;
      req_1 = 1'b1; pc_1 = 32'h5000;
      tick();
      req_1 = 1'b0;
      checks++; if (arvalid !== 1'b1 || busy_1 !== 1'b1) begin errors++; $display("FAIL areset_pre got %h/%h exp 1/1", arvalid, busy_1); end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (arvalid !== 1'b0 || araddr !== 32'h0) begin errors++; $display("FAIL areset_ar got %h/%h exp 0/0", arvalid, araddr); end
      checks++; if ({busy_1, busy_2} !== 2'b00) begin errors++; $display("FAIL areset_busy got %b exp 00", {busy_1, busy_2}); end
      #2;
      reset = 1'b0;
      tick();
      checks++; if (arvalid !== 1'b0 || rready !== 1'b0) begin errors++; $display("FAIL areset_idle got %h/%h exp 0/0", arvalid, rready); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_flush_data();
      test_misaligned();
      test_rresp_err();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
